// File: rtl/or_req_arb_if.sv
// ----------------------------------------------------------------------------
// or_req_arb_if
//   Oursring master port bundle used by or_req_arb: AR/AW/W request channels
//   and R/B response channels.
//
//   Field widths: address 40 bits, data 64 bits, transaction id (ring_tid_t)
//   4 bits, write strobe 8 bits.
//
//   Handshake rule on every channel: a transfer happens on a rising clock edge
//   where both valid and ready are 1. The source raises valid, holds it and its
//   payload stable, and drops it only after that transfer. The sink may raise or
//   drop ready at any time, and ready never depends on future cycles.
//
//   Modports:
//     master - drives ar*/aw*/w* payload and valids, rready, bready
//     slave  - drives arready, awready, wready, rvalid/rdata, bvalid
// ----------------------------------------------------------------------------
interface or_req_arb_if;
  // AR channel
  logic        arvalid;
  logic        arready;
  logic [39:0] araddr;
  logic [3:0]  arid;
  // AW channel
  logic        awvalid;
  logic        awready;
  logic [39:0] awaddr;
  logic [3:0]  awid;
  // W channel
  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  // R channel
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  // B channel
  logic        bvalid;
  logic        bready;

  modport master (
    output arvalid, araddr, arid,
    output awvalid, awaddr, awid,
    output wvalid, wdata, wstrb, wlast,
    output rready, bready,
    input  arready, awready, wready,
    input  rvalid, rdata, bvalid
  );

  modport slave (
    input  arvalid, araddr, arid,
    input  awvalid, awaddr, awid,
    input  wvalid, wdata, wstrb, wlast,
    input  rready, bready,
    output arready, awready, wready,
    output rvalid, rdata, bvalid
  );
endinterface

// File: rtl/or_req_arb.sv
// ----------------------------------------------------------------------------
// or_req_arb
//   Round-robin arbiter sharing one oursring master port among N_REQ simple
//   command requesters. One transaction in flight at a time: a read runs AR then
//   R, a write runs AW+W (in any order) then B. The read data or write ack is
//   returned to the owning requester as a one-cycle rsp_vld pulse.
//
//   Optional feature macro: OR_REQ_ARB_TIMEOUT_EN
//     Defined     - a response watchdog ends a stuck transaction after
//                   TIMEOUT_CYC cycles with rsp_err=1.
//     Not defined - no watchdog, the FSM waits indefinitely, rsp_err_o is 0.
//
// Parameters
//   N_REQ        number of requesters, 2..8
//   TIMEOUT_CYC  watchdog limit in cycles (only with OR_REQ_ARB_TIMEOUT_EN), >= 2
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_vld_i       per-requester command valid (held until req_rdy_o)
//   req_rdy_o       per-requester command accept, one-hot or zero
//   req_wr_i        per-requester 1=write 0=read
//   req_addr_i      requester i address at [40*i +: 40]
//   req_wdata_i     requester i write data at [64*i +: 64]
//   rsp_vld_o       one-cycle response pulse to the owning requester
//   rsp_rdata_o     last read data (shared)
//   rsp_err_o       response error flag (shared)
//   state_o         current FSM state, for debug
//   ring            oursring master port
// ----------------------------------------------------------------------------
module or_req_arb #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_vld_i,
  output logic [N_REQ-1:0]    req_rdy_o,
  input  logic [N_REQ-1:0]    req_wr_i,
  input  logic [N_REQ*40-1:0] req_addr_i,
  input  logic [N_REQ*64-1:0] req_wdata_i,
  output logic [N_REQ-1:0]    rsp_vld_o,
  output logic [63:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [2:0]          state_o,
  or_req_arb_if.master        ring
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RREQ         = 3'd1,
    RRSP         = 3'd2,
    WREQ         = 3'd3,
    WAIT_AWREADY = 3'd4,
    WAIT_WREADY  = 3'd5,
    WRSP         = 3'd6,
    RSP          = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  rr_ptr_q;
  logic [2:0]  owner_q;
  logic [39:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rsp_rdata_q;

  logic        win_found;
  logic [2:0]  win_idx;
  logic [2:0]  rr_next;
  logic        accept;
  logic        sel_wr;
  logic [39:0] sel_addr;
  logic [63:0] sel_wdata;
  logic        r_hs;
  logic        b_hs;
  logic        busy;
  logic        timeout_hit;

  // Winner: first valid requester at or above rr_ptr, then wrap to those below.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!win_found && req_vld_i[j] && (j >= int'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_idx   = 3'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!win_found && req_vld_i[j] && (j < int'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_idx   = 3'(j);
      end
    end
  end

  // Reset gates the accept so nothing is granted while rst is held.
  assign accept  = (state_q == IDLE) && win_found && !rst;
  assign rr_next = (win_idx == 3'(N_REQ - 1)) ? 3'd0 : win_idx + 3'd1;

  // Mux the winner's command fields and drive its one-hot accept.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    req_rdy_o = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (3'(j) == win_idx) begin
        sel_wr       = req_wr_i[j];
        sel_addr     = req_addr_i[40*j +: 40];
        sel_wdata    = req_wdata_i[64*j +: 64];
        req_rdy_o[j] = accept;
      end
    end
  end

  always_comb begin
    rsp_vld_o = '0;
    for (int j = 0; j < N_REQ; j++) begin
      rsp_vld_o[j] = (state_q == RSP) && (owner_q == 3'(j));
    end
  end

  // Channel controls are pure state decodes, so a valid stays up until the
  // state advances, which only happens on its own ready.
  assign ring.arvalid = (state_q == RREQ);
  assign ring.awvalid = (state_q == WREQ) || (state_q == WAIT_AWREADY);
  assign ring.wvalid  = (state_q == WREQ) || (state_q == WAIT_WREADY);
  assign ring.rready  = (state_q == RRSP);
  assign ring.bready  = (state_q == WRSP);
  assign ring.araddr  = addr_q;
  assign ring.awaddr  = addr_q;
  assign ring.arid    = {1'b0, owner_q};
  assign ring.awid    = {1'b0, owner_q};
  assign ring.wdata   = wdata_q;
  assign ring.wstrb   = 8'hff;
  assign ring.wlast   = 1'b1;

  assign r_hs    = ring.rready && ring.rvalid;
  assign b_hs    = ring.bready && ring.bvalid;
  assign busy    = (state_q != IDLE) && (state_q != RSP);
  assign state_o = state_q;
  assign rsp_rdata_o = rsp_rdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (accept) state_d = sel_wr ? WREQ : RREQ;
      RREQ:         if (ring.arready) state_d = RRSP;
      RRSP:         if (ring.rvalid) state_d = RSP;
      WREQ: begin
        case ({ring.awready, ring.wready})
          2'b11:   state_d = WRSP;
          2'b10:   state_d = WAIT_WREADY;
          2'b01:   state_d = WAIT_AWREADY;
          default: state_d = WREQ;
        endcase
      end
      WAIT_AWREADY: if (ring.awready) state_d = WRSP;
      WAIT_WREADY:  if (ring.wready) state_d = WRSP;
      WRSP:         if (ring.bvalid) state_d = RSP;
      RSP:          state_d = IDLE;
      default:      state_d = IDLE;
    endcase
    if (timeout_hit) state_d = RSP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q  <= win_idx;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        rr_ptr_q <= rr_next;
      end
      if (r_hs) rsp_rdata_q <= ring.rdata;
    end
  end

`ifdef OR_REQ_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             rsp_err_q, rsp_err_d;

  // to_cnt_q is 0 in the first cycle after accept, so the cycle holding value
  // TIMEOUT_CYC-2 is TIMEOUT_CYC-1 cycles after accept; RSP then lands exactly
  // TIMEOUT_CYC cycles after accept. A completing handshake in that same cycle
  // wins over the timeout.
  assign timeout_hit = busy && (to_cnt_q == CNT_W'(TIMEOUT_CYC - 2)) && !r_hs && !b_hs;

  always_comb begin
    to_cnt_d  = to_cnt_q;
    rsp_err_d = rsp_err_q;
    if (accept)    to_cnt_d = '0;
    else if (busy) to_cnt_d = to_cnt_q + 1'b1;
    if (r_hs || b_hs)     rsp_err_d = 1'b0;
    else if (timeout_hit) rsp_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_or_req_arb.sv
module tb_or_req_arb;
  localparam int N  = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_rdy;
  logic [N-1:0]    req_wr;
  logic [N*40-1:0] req_addr;
  logic [N*64-1:0] req_wdata;
  logic [N-1:0]    rsp_vld;
  logic [63:0]     rsp_rdata;
  logic            rsp_err;
  logic [2:0]      state;

  or_req_arb_if ring();

  or_req_arb #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld_i   (req_vld),
    .req_rdy_o   (req_rdy),
    .req_wr_i    (req_wr),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_vld_o   (rsp_vld),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .state_o     (state),
    .ring        (ring)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic        wr;
    logic [39:0] addr;
    logic [63:0] wdata;
    int          ar_d;
    int          aw_d;
    int          w_d;
    int          r_d;
    int          b_d;
    logic [63:0] rdata;
    int          exp_lat;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];
  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic [63:0] exp_q[$];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic slave_idle();
    ring.arready = 1'b0;
    ring.awready = 1'b0;
    ring.wready  = 1'b0;
    ring.rvalid  = 1'b0;
    ring.bvalid  = 1'b0;
    ring.rdata   = '0;
  endtask

  task automatic slave_clear_cnt();
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
  endtask

  // Called at a negedge: decides slave inputs for the coming posedge. Each ready
  // or response valid rises once its channel has waited the requested cycles.
  task automatic slave_step(input vec_t v);
    ring.arready = ring.arvalid && (ar_cnt >= v.ar_d);
    if (ring.arvalid) ar_cnt++;
    ring.awready = ring.awvalid && (aw_cnt >= v.aw_d);
    if (ring.awvalid) aw_cnt++;
    ring.wready = ring.wvalid && (w_cnt >= v.w_d);
    if (ring.wvalid) w_cnt++;
    ring.rvalid = ring.rready && (r_cnt >= v.r_d);
    if (ring.rready) r_cnt++;
    ring.bvalid = ring.bready && (b_cnt >= v.b_d);
    if (ring.bready) b_cnt++;
    ring.rdata = v.rdata;
  endtask

  task automatic drive_req(input vec_t v);
    req_vld[v.idx]             = 1'b1;
    req_wr[v.idx]              = v.wr;
    req_addr[40*v.idx +: 40]   = v.addr;
    req_wdata[64*v.idx +: 64]  = v.wdata;
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int acc_c = -1;
    int rsp_c = -1;
    int proto = 0;
    bit aw_hs = 0;
    bit w_hs  = 0;
    logic [N-1:0] grant = '0;
    slave_clear_cnt();
    drive_req(v);
    for (int c = 0; c < 80 && rsp_c < 0; c++) begin
      @(negedge clk);
      if (req_rdy != '0 && acc_c < 0) begin
        acc_c = c;
        grant = req_rdy;
      end
      if (ring.arvalid && ar_cnt == 0) begin
        check({tag, "_araddr"}, 64'(ring.araddr), 64'(v.addr));
        check({tag, "_arid"}, 64'(ring.arid), 64'(v.idx));
      end
      if (ring.awvalid && aw_cnt == 0) begin
        check({tag, "_awaddr"}, 64'(ring.awaddr), 64'(v.addr));
        check({tag, "_awid"}, 64'(ring.awid), 64'(v.idx));
      end
      if (ring.wvalid && w_cnt == 0) begin
        check({tag, "_wdata"}, ring.wdata, v.wdata);
        check({tag, "_wstrb_wlast"}, 64'({ring.wstrb, ring.wlast}), 64'h1ff);
      end
      if (aw_hs && ring.awvalid) proto++;
      if (w_hs && ring.wvalid) proto++;
      if (rsp_vld != '0) begin
        rsp_c = c;
        check({tag, "_rsp_owner"}, 64'(rsp_vld), 64'(1 << v.idx));
        check({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
        check({tag, "_ring_quiet"}, 64'({ring.arvalid, ring.awvalid, ring.wvalid,
                                         ring.rready, ring.bready}), 64'h0);
      end
      slave_step(v);
      if (ring.awready) aw_hs = 1;
      if (ring.wready) w_hs = 1;
      @(posedge clk);
      #1;
      if (acc_c == c) req_vld[v.idx] = 1'b0;
    end
    check({tag, "_accept_cycle"}, 64'(acc_c), 64'(0));
    check({tag, "_grant"}, 64'(grant), 64'(1 << v.idx));
    check({tag, "_latency"}, 64'(rsp_c - acc_c), 64'(v.exp_lat));
    check({tag, "_valid_held_to_hs"}, 64'(proto), 64'(0));
    @(negedge clk);
    check({tag, "_rsp_one_cycle"}, 64'({rsp_vld, state}), 64'(0));
    slave_idle();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin : main
    int n_rsp;
    int n_grant;
    int bad;
    vec_t v;

    //          idx wr addr                 wdata                    ar aw w  r  b  rdata                     lat exp_rdata              err
    vecs[0] = '{0, 0, 40'h10,          64'h0,                   0, 0, 0, 0, 0, 64'h1111_2222_3333_4444, 3, 64'h1111_2222_3333_4444, 0};
    vecs[1] = '{1, 0, 40'h80,          64'h0,                   0, 0, 0, 0, 0, 64'hDEAD_BEEF_CAFE_F00D, 3, 64'hDEAD_BEEF_CAFE_F00D, 0};
    vecs[2] = '{0, 1, 40'h40,          64'h1234,                0, 2, 5, 0, 1, 64'h5555_5555_5555_5555, 9, 64'hDEAD_BEEF_CAFE_F00D, 0};
    vecs[3] = '{1, 0, 40'h100,         64'h0,                   3, 0, 0, 2, 0, 64'hA5A5_5A5A_0123_4567, 8, 64'hA5A5_5A5A_0123_4567, 0};
    vecs[4] = '{1, 1, 40'h208,         64'hFFFF_0000_FFFF_0000, 0, 4, 0, 0, 0, 64'h7777_7777_7777_7777, 7, 64'hA5A5_5A5A_0123_4567, 0};
    vecs[5] = '{0, 1, 40'hFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 2, 64'h6666_6666_6666_6666, 5, 64'hA5A5_5A5A_0123_4567, 0};
    vecs[6] = '{1, 0, 40'hFF_FFFF_FFF8, 64'h0,                   1, 0, 0, 1, 0, 64'h0,                   5, 64'h0,                   0};

    rst       = 1'b1;
    req_vld   = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    slave_idle();

    // Reset: held 3 cycles with a request pending; nothing may be granted.
    req_vld[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_rdy", 64'(req_rdy), 64'h0);
    check("reset_outputs", 64'({rsp_vld, rsp_err, state, ring.arvalid, ring.awvalid,
                                ring.wvalid, ring.rready, ring.bready}), 64'h0);
    check("reset_rsp_rdata", rsp_rdata, 64'h0);
    req_vld = '0;
    rst     = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven single transactions.
    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while waiting for B: bready drops, later bvalid is ignored.
    v = '{0, 1, 40'h300, 64'hABCD, 0, 0, 0, 0, 1000, 64'h0, 0, 64'h0, 0};
    slave_clear_cnt();
    drive_req(v);
    n_grant = 0;
    begin : reach_wrsp
      bit acc;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (ring.bready) begin
          n_grant = 1;
          break;
        end
        acc = (req_rdy != '0);
        slave_step(v);
        @(posedge clk);
        #1;
        if (acc) req_vld = '0;
      end
    end
    check("midrst_reached_wrsp", 64'(n_grant), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bready_state", 64'({ring.bready, state}), 64'h0);
    check("midrst_rsp_rdata", rsp_rdata, 64'h0);
    rst = 1'b0;
    slave_idle();
    ring.bvalid = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_vld != '0 || ring.bready || state != 3'd0) bad++;
    end
    check("midrst_late_b_ignored", 64'(bad), 64'(0));
    slave_idle();

    // Fairness: both requesters held valid; grants must alternate from 0.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) exp_q.push_back(64'(k % 2));
    v = '{0, 0, 40'h0, 64'h0, 0, 0, 0, 0, 0, 64'h0F0F_0F0F_F0F0_F0F0, 0, 64'h0, 0};
    req_vld            = 2'b11;
    req_wr             = 2'b00;
    req_addr[0 +: 40]  = 40'h1000;
    req_addr[40 +: 40] = 40'h2000;
    n_rsp   = 0;
    n_grant = 0;
    for (int c = 0; c < 100 && n_rsp < 6; c++) begin
      logic [63:0] g;
      @(negedge clk);
      if (req_rdy != '0) begin
        g = req_rdy[1] ? 64'd1 : 64'd0;
        n_grant++;
        if (exp_q.size() == 0) check("fair_extra_grant", g, 64'hFFFF);
        else check($sformatf("fair_grant%0d", n_grant), g, exp_q.pop_front());
      end
      if (rsp_vld != '0) n_rsp++;
      slave_clear_cnt();
      slave_step(v);
      @(posedge clk);
      #1;
      if (n_grant == 6) req_vld = '0;
    end
    check("fair_rsp_count", 64'(n_rsp), 64'(6));
    check("fair_queue_empty", 64'(exp_q.size()), 64'(0));
    check("fair_last_rdata", rsp_rdata, 64'h0F0F_0F0F_F0F0_F0F0);
    slave_idle();
    @(posedge clk);
    #1;

`ifdef OR_REQ_ARB_TIMEOUT_EN
    // Timeout: arready never comes; error response TO cycles after accept.
    v = '{0, 0, 40'h500, 64'h0, 100000, 0, 0, 0, 0, 64'h9999_9999_9999_9999, TO,
          64'h0F0F_0F0F_F0F0_F0F0, 1};
    do_txn(v, "timeout");
    ring.rvalid = 1'b1;
    ring.rdata  = 64'h1234_5678_9ABC_DEF0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (ring.rready || rsp_vld != '0) bad++;
    end
    check("timeout_late_r_ignored", 64'(bad), 64'(0));
    check("timeout_rdata_kept", rsp_rdata, 64'h0F0F_0F0F_F0F0_F0F0);
    slave_idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
